data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
// - Responder end of the datapath data-memory request interface. Accepts req/addr/byte_en/wr/wr_data
//   from the memory stage and services it from an on-chip byte-addressable RAM.
// - Returns read data right-justified in bits [N*8-1:0]. The memory stage performs sign/zero extension.
// - Flags misaligned and out-of-range accesses. Sits between the memory stage and the (future) AXI bridge.
// PARAMETERS
// - MEM_SIZE    512*1024  RAM capacity in bytes; power of two, multiple of 8
// - BASE_ADDR   64'h0     byte address mapped to RAM offset 0
// - DEPTH       MEM_SIZE/8  (localparam) number of 64-bit RAM rows
// PORTS
// - clk                 in   1   clock, all state on rising edge
// - reset_n             in   1   asynchronous, active-low reset
// - data_mem_req_i      in   1   request valid this cycle
// - data_mem_addr_i     in   64  byte address
// - data_mem_byte_en_i  in   2   access size: BYTE, HALF_WORD, WORD, DOUBLE (cpu_consts)
// - data_mem_wr_i       in   1   1 = store, 0 = load
// - data_mem_wr_data_i  in   64  store data, right-justified
// - mem_rd_data_o       out  64  load data, right-justified, upper bits zero
// - mem_rd_valid_o      out  1   mem_rd_data_o valid (one cycle pulse per load)
// - mem_wr_done_o       out  1   store committed (one cycle pulse per store)
// - mem_err_o           out  1   response for this request is an error (misaligned or out of range)
// - mem_err_addr_o      out  64  address of the most recent erroring request (sticky until next error)
// BEHAVIOUR
// - Reset (reset_n low, async): all outputs 0, response pipeline cleared. RAM contents are NOT reset.
// - Latency: a request accepted in cycle N produces its response (rd_valid / wr_done / err) in cycle N+1.
//   A new request is accepted every cycle; there is no backpressure.
// - Decode: off = addr - BASE_ADDR; row = off[$clog2(MEM_SIZE)-1:3]; lane = off[2:0].
// - Alignment: HALF_WORD needs lane[0]==0, WORD needs lane[1:0]==0, DOUBLE needs lane==0.
// - Range: in-range iff addr >= BASE_ADDR and off + size - 1 < MEM_SIZE.
// - Error (misaligned OR out of range):
//   - No RAM write.
//   - Cycle N+1: mem_err_o=1, mem_rd_data_o=0, rd_valid=0 and wr_done=0.
//   - mem_err_addr_o loaded with addr.
// - Store:
//   - Byte-enable mask = size mask << lane.
//   - wr_data shifted left by lane*8; only masked bytes of RAM[row] are updated at the edge ending cycle N.
//   - Cycle N+1: wr_done=1.
// - Load:
//   - RAM[row] read synchronously and shifted right by lane*8 (lane registered in cycle N).
//   - Bytes above size are masked to 0.
//   - Cycle N+1: rd_valid=1.
// - Read-after-write: a store in cycle N followed by a load in N+1 to an overlapping address returns the
//   new data in N+2 (write-first RAM; no forwarding required).
// - Reset asserted mid-operation: a pending response is dropped (no rd_valid/wr_done pulse after reset).
//   A store accepted in the cycle reset asserts may or may not commit.
// - data_mem_req_i=0: no RAM access. In N+1, valid/done/err are all 0 and mem_rd_data_o holds its last value.
// STRUCTURE
// - cpu_consts (shared package): size codes BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b10, DOUBLE=2'b11;
//   function size_mask(size) returning 8-bit byte mask; typedef mem_resp_t {valid, wr, err, lane, size}.
// - Sub-module mem_lane_align: combinational.
//   - Store path: {size, lane, wr_data} -> {byte_mask, shifted data, misaligned}.
//   - Load path: {size, lane, row data} -> right-justified masked data.
// - Top holds: RAM array (synthesises to BRAM), one-stage response register, sticky error-address register.
// TESTING
// - Reset: hold reset_n=0 with req=1 -> all outputs 0. Release -> first response only for a req after release.
// - DOUBLE store 64'h0123_4567_89AB_CDEF @0x10, then DOUBLE load @0x10
//   -> wr_done in N+1; rd_data 64'h0123_4567_89AB_CDEF with rd_valid in N+3.
// - BYTE store 8'hA5 @0x13 over row 0x10 = all 1s, then DOUBLE load @0x10
//   -> 64'hFFFF_FFFF_A5FF_FFFF (only lane 3 changed).
// - WORD load @0x14 of row 64'h8000_0001_0000_0000
//   -> rd_data 64'h0000_0000_8000_0001 (right-justified, no extension).
// - Misaligned WORD store @0x12 -> mem_err_o=1, err_addr=0x12, no wr_done; subsequent load @0x10 shows RAM unchanged.
// - Out-of-range BYTE load @MEM_SIZE -> err=1, rd_data=0.
//   Back-to-back store @0x20 then load @0x20 on consecutive cycles -> load returns new data.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared access-size codes, byte-mask helper and the registered response record.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10,
    DOUBLE    = 2'b11
  } size_e;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       err;
    logic [2:0] lane;
    size_e      size;
  } mem_resp_t;

  function automatic logic [7:0] size_mask(size_e size);
    case (size)
      BYTE:      return 8'h01;
      HALF_WORD: return 8'h03;
      WORD:      return 8'h0F;
      default:   return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage request / responder response bundle; the memory stage is the master.
interface data_mem_responder_if;
  logic        data_mem_req_i;
  logic [63:0] data_mem_addr_i;
  logic [1:0]  data_mem_byte_en_i;
  logic        data_mem_wr_i;
  logic [63:0] data_mem_wr_data_i;
  logic [63:0] mem_rd_data_o;
  logic        mem_rd_valid_o;
  logic        mem_wr_done_o;
  logic        mem_err_o;
  logic [63:0] mem_err_addr_o;

  modport master (
    output data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i, data_mem_wr_i, data_mem_wr_data_i,
    input  mem_rd_data_o, mem_rd_valid_o, mem_wr_done_o, mem_err_o, mem_err_addr_o
  );

  modport slave (
    input  data_mem_req_i, data_mem_addr_i, data_mem_byte_en_i, data_mem_wr_i, data_mem_wr_data_i,
    output mem_rd_data_o, mem_rd_valid_o, mem_wr_done_o, mem_err_o, mem_err_addr_o
  );
endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational lane steering: store data/mask placement and misalignment on the request side,
// right-justify and size-mask of the registered RAM row on the load side.
module data_mem_responder_mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  size_e       req_size,
  input  logic [2:0]  req_lane,
  input  logic [63:0] wr_data,
  output logic [7:0]  byte_mask,
  output logic [63:0] wr_shifted,
  output logic        misaligned,
  input  size_e       ld_size,
  input  logic [2:0]  ld_lane,
  input  logic [63:0] row_data,
  output logic [63:0] rd_data
);

  logic [7:0]  req_mask;
  logic [7:0]  ld_mask;
  logic [63:0] ld_shift;
  logic [63:0] ld_bits;

  always_comb begin
    req_mask   = size_mask(req_size);
    byte_mask  = req_mask << req_lane;
    wr_shifted = wr_data << {req_lane, 3'b000};
    // {m[4],m[2],m[1]} is (size_in_bytes - 1), the lane bits that must be zero
    misaligned = |(req_lane & {req_mask[4], req_mask[2], req_mask[1]});

    ld_mask  = size_mask(ld_size);
    ld_shift = row_data >> {ld_lane, 3'b000};
    ld_bits  = '0;
    for (int b = 0; b < 8; b++) begin
      ld_bits[b*8 +: 8] = {8{ld_mask[b]}};
    end
    rd_data = ld_shift & ld_bits;
  end

endmodule

// File: rtl/data_mem_responder.sv
// On-chip byte-addressable data RAM answering memory-stage requests one cycle after acceptance.
// A request is taken every cycle with no backpressure; misaligned or out-of-range requests error out.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 512 * 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input logic clk,
  input logic reset_n,
  data_mem_responder_if.slave bus
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int DEPTH = MEM_SIZE / 8;

  logic [63:0] mem [0:DEPTH-1];

  logic [63:0]   off;
  logic [AW-4:0] row;
  logic [2:0]    lane;
  size_e         req_size;
  logic          in_range;
  logic          misaligned;
  logic          req_err;
  logic          wr_en;
  logic          rd_en;
  logic [7:0]    byte_mask;
  logic [63:0]   wr_shifted;
  logic [63:0]   ram_q;
  logic [63:0]   aligned;
  mem_resp_t     resp_q;
  logic          data_zero;
  logic [63:0]   err_addr_q;

  assign off      = bus.data_mem_addr_i - BASE_ADDR;
  assign row      = off[AW-1:3];
  assign lane     = off[2:0];
  assign req_size = size_e'(bus.data_mem_byte_en_i);
  // Aligned accesses never straddle a row, so staying below MEM_SIZE covers the whole access.
  assign in_range = (bus.data_mem_addr_i >= BASE_ADDR) && ((off >> AW) == 64'd0);
  assign req_err  = bus.data_mem_req_i & (misaligned | ~in_range);
  assign wr_en    = bus.data_mem_req_i &  bus.data_mem_wr_i & ~req_err;
  assign rd_en    = bus.data_mem_req_i & ~bus.data_mem_wr_i & ~req_err;

  data_mem_responder_mem_lane_align u_align (
    .req_size   (req_size),
    .req_lane   (lane),
    .wr_data    (bus.data_mem_wr_data_i),
    .byte_mask  (byte_mask),
    .wr_shifted (wr_shifted),
    .misaligned (misaligned),
    .ld_size    (resp_q.size),
    .ld_lane    (resp_q.lane),
    .row_data   (ram_q),
    .rd_data    (aligned)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_mask[b]) mem[row][b*8 +: 8] <= wr_shifted[b*8 +: 8];
      end
    end
    if (rd_en) ram_q <= mem[row];
  end

  // data_zero forces the load data to zero after reset/error and keeps it there until the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_q     <= '0;
      data_zero  <= 1'b1;
      err_addr_q <= '0;
    end else begin
      resp_q.valid <= bus.data_mem_req_i;
      resp_q.wr    <= bus.data_mem_wr_i;
      resp_q.err   <= req_err;
      if (rd_en) begin
        resp_q.lane <= lane;
        resp_q.size <= req_size;
        data_zero   <= 1'b0;
      end else if (req_err) begin
        data_zero <= 1'b1;
      end
      if (req_err) err_addr_q <= bus.data_mem_addr_i;
    end
  end

  assign bus.mem_rd_valid_o = resp_q.valid & ~resp_q.wr & ~resp_q.err;
  assign bus.mem_wr_done_o  = resp_q.valid &  resp_q.wr & ~resp_q.err;
  assign bus.mem_err_o      = resp_q.valid &  resp_q.err;
  assign bus.mem_rd_data_o  = data_zero ? 64'd0 : aligned;
  assign bus.mem_err_addr_o = err_addr_q;

endmodule
